// File: rtl/motor_pwm_if.sv
// Motor PWM controller bus: per-channel commands in, bridge drive and status out.
interface motor_pwm_if #(
    parameter int CH    = 2,
    parameter int CNT_W = 16
);
    logic [CH-1:0]       enable;
    logic [CH-1:0]       direct;
    logic [CH-1:0]       brake;
    logic                ld;
    logic [CH*CNT_W-1:0] duty_tgt;
    logic [2*CH-1:0]     MA;
    logic                period_tick;
    logic [CH-1:0]       ramp_done;

    modport master (
        output enable, direct, brake, ld, duty_tgt,
        input  MA, period_tick, ramp_done
    );

    modport slave (
        input  enable, direct, brake, ld, duty_tgt,
        output MA, period_tick, ramp_done
    );
endinterface

// File: rtl/motor_pwm_ctrl.sv
// Multi-channel H-bridge PWM with soft-start ramp, safe reversal,
// brake and coast; duty changes apply only at period boundaries.
module motor_pwm_ctrl #(
    parameter int CH        = 2,
    parameter int CNT_W     = 16,
    parameter int PERIOD    = 10000,
    parameter int DEAD      = 50,
    parameter int RAMP_DIV  = 1000,
    parameter int RAMP_STEP = 10
) (
    input logic        sclk,
    input logic        s_rst_n,
    motor_pwm_if.slave bus
);
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = $clog2(DEAD + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] PMAX  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] STEP  = CNT_W'(RAMP_STEP);
    localparam logic [PW-1:0]    PLAST = PW'(RAMP_DIV - 1);
    localparam logic [DW-1:0]    DLOAD = DW'(DEAD);

    typedef enum logic [2:0] {
        COAST, RUN, REVERSE, DEAD_T, BRAKE
    } state_t;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [PW-1:0]    r_pre;
    logic             r_tick;
    logic             w_wrap;
    logic             w_ramp;
    logic [2*CH-1:0]  w_ma_all;
    logic [CH-1:0]    w_done_all;

    assign w_wrap    = (r_cnt == LAST);
    assign w_ramp    = (r_pre == PLAST);
    assign w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_cnt  <= '0;
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_pre  <= w_ramp ? '0 : r_pre + 1'b1;
            r_tick <= (w_cnt_nxt == LAST);
        end
    end

    assign bus.period_tick = r_tick;
    assign bus.MA          = w_ma_all;
    assign bus.ramp_done   = w_done_all;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t           r_st, w_st;
        logic [CNT_W-1:0] r_tgt, w_tgt, w_req;
        logic [CNT_W-1:0] r_cur, w_cur;
        logic [CNT_W-1:0] r_act, w_act;
        logic [CNT_W-1:0] w_goal, w_diff, w_step;
        logic [DW-1:0]    r_dead, w_dead;
        logic             r_dir, w_dir;
        logic             r_done, w_done;
        logic [1:0]       r_ma, w_ma;
        logic             w_raw;

        assign w_req = bus.duty_tgt[g*CNT_W +: CNT_W];
        assign w_tgt = bus.ld ? ((w_req > PMAX) ? PMAX : w_req) : r_tgt;
        assign w_raw = (r_cnt < r_act);

        always_comb begin
            w_st   = r_st;
            w_cur  = r_cur;
            w_act  = r_act;
            w_dead = r_dead;
            w_dir  = r_dir;
            w_goal = (r_st == REVERSE) ? '0 : w_tgt;
            w_diff = (w_goal > r_cur) ? w_goal - r_cur : r_cur - w_goal;
            w_step = (w_diff > STEP) ? STEP : w_diff;
            if (w_ramp && (r_st == RUN || r_st == REVERSE))
                w_cur = (w_goal > r_cur) ? r_cur + w_step : r_cur - w_step;
            unique case (r_st)
                COAST: begin
                    w_st  = RUN;
                    w_dir = bus.direct[g];
                end
                RUN: if (bus.direct[g] != r_dir) w_st = REVERSE;
                REVERSE: if (r_cur == '0 && r_act == '0) begin
                    w_st   = DEAD_T;
                    w_dead = DLOAD;
                end
                DEAD_T: begin
                    w_dead = r_dead - 1'b1;
                    if (r_dead == DW'(1)) begin
                        w_st  = RUN;
                        w_dir = bus.direct[g];
                    end
                end
                BRAKE: if (!bus.brake[g]) w_st = COAST;
                default: w_st = COAST;
            endcase
            // Post-step cur is what the boundary captures
            if (w_wrap) w_act = w_cur;
            if (!bus.enable[g]) begin
                w_st  = COAST;
                w_cur = '0;
                w_act = '0;
            end else if (bus.brake[g] && r_st != BRAKE) begin
                w_st  = BRAKE;
                w_cur = '0;
                w_act = '0;
            end
            unique case (w_st)
                RUN, REVERSE: w_ma = r_dir ? {1'b0, w_raw} : {w_raw, 1'b0};
                BRAKE:        w_ma = 2'b11;
                default:      w_ma = 2'b00;
            endcase
            w_done = (w_st == RUN) && (w_cur == w_tgt);
        end

        always_ff @(posedge sclk or negedge s_rst_n) begin
            if (!s_rst_n) begin
                r_st   <= COAST;
                r_tgt  <= '0;
                r_cur  <= '0;
                r_act  <= '0;
                r_dead <= '0;
                r_dir  <= 1'b1;
                r_ma   <= 2'b00;
                r_done <= 1'b0;
            end else begin
                r_st   <= w_st;
                r_tgt  <= w_tgt;
                r_cur  <= w_cur;
                r_act  <= w_act;
                r_dead <= w_dead;
                r_dir  <= w_dir;
                r_ma   <= w_ma;
                r_done <= w_done;
            end
        end

        assign w_ma_all[2*g +: 2] = r_ma;
        assign w_done_all[g]      = r_done;
    end
endmodule
